// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types (request/response/burst order) plus the arbiter state encoding.
package cbus_arbiter_pkg;

    // Burst length is 2**order words.
    typedef enum logic [2:0] {
        ORDER_1  = 3'd0,
        ORDER_2  = 3'd1,
        ORDER_4  = 3'd2,
        ORDER_8  = 3'd3,
        ORDER_16 = 3'd4
    } cbus_order_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        cbus_order_t order;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        okay;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_picker.sv
// Combinational winner selection: round-robin from rr_ptr, or lowest index when
// CBUS_ARB_FIXED_PRIORITY_EN is defined (rr_ptr then ignored).
module cbus_rr_picker
    import cbus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 3,
    localparam int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [IDX_BITS-1:0] rr_ptr,
    output logic [IDX_BITS-1:0] winner,
    output logic                any_valid
);

`ifdef CBUS_ARB_FIXED_PRIORITY_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        winner    = '0;
        any_valid = |valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[k]) winner = IDX_BITS'(k);
        end
    end
`else
    localparam int SW = IDX_BITS + 1;

    logic [SW-1:0]       sum;
    logic [IDX_BITS-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        winner    = '0;
        any_valid = |valid;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
            idx = sum[IDX_BITS-1:0];
            if (valid[idx]) winner = idx;
        end
    end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one CBus burst channel among NUM_REQ masters; grant held until resp okay+last.
// Round-robin by default, fixed priority with CBUS_ARB_FIXED_PRIORITY_EN. One idle cycle per arbitration.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 3,
    localparam int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  cbus_req_t           req_in   [NUM_REQ],
    output cbus_resp_t          resp_out [NUM_REQ],
    output cbus_req_t           req_out,
    input  cbus_resp_t          resp_in,
    output logic                busy,
    output logic [IDX_BITS-1:0] grant_idx
);

    arb_state_t          state, state_nxt;
    logic [IDX_BITS-1:0] owner, owner_nxt;
    logic [IDX_BITS-1:0] rr_ptr, rr_nxt;
    logic [NUM_REQ-1:0]  valid_vec;
    logic [IDX_BITS-1:0] winner;
    logic                any_valid;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = req_in[i].valid;
    end

    cbus_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid     (valid_vec),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    owner_nxt = winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (resp_in.okay && resp_in.last) begin
                    state_nxt = IDLE;
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
                    // NUM_REQ need not be a power of two, so wrap explicitly.
                    rr_nxt = (owner == IDX_BITS'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_out       = req_in[owner];
        req_out.valid = (state == GRANT) && req_in[owner].valid;
        for (int j = 0; j < NUM_REQ; j++) begin
            resp_out[j].okay  = 1'b0;
            resp_out[j].last  = 1'b0;
            resp_out[j].rdata = resp_in.rdata;
            if ((state == GRANT) && (IDX_BITS'(j) == owner)) resp_out[j] = resp_in;
        end
    end

    assign busy      = (state == GRANT);
    assign grant_idx = owner;

    // The owner must keep valid asserted until its burst completes.
    owner_holds_valid: assert property (@(posedge clk) disable iff (reset)
        (state == GRANT) |-> req_in[owner].valid);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: cycle vector table plus burst-level sequences.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  req    [3];
    cbus_resp_t resp_o [3];
    cbus_req_t  req_o;
    cbus_resp_t resp_i;
    logic       busy;
    logic [1:0] grant_idx;

    int checks   = 0;
    int failures = 0;

    cbus_arbiter #(.NUM_REQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req),
        .resp_out  (resp_o),
        .req_out   (req_o),
        .resp_in   (resp_i),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] vld;
        logic       okay;
        logic       last;
        logic       busy;
        logic [1:0] gidx;
        logic       rov;
        logic [2:0] okays;
        logic [2:0] lasts;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            req[k].valid    = 1'b0;
            req[k].is_write = 1'b0;
            req[k].addr     = 32'h100 * (k + 1);
            req[k].order    = ORDER_2;
            req[k].wdata    = 32'h0;
        end
        resp_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [2:0] okay_vec();
        return {resp_o[2].okay, resp_o[1].okay, resp_o[0].okay};
    endfunction

    initial begin
        vec_t vecs [17];
        logic [63:0] act, exp;
        int rd_err, n_ok, early_last, other_ok, seq_err, bubble_err;
        int wd_err, addr_err, gidx_err, win1;
        int cnt [3];

        // vld, okay, last | busy, gidx, req_out.valid, okays, lasts
        vecs[0]  = '{3'b101, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[1]  = '{3'b101, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b000};
        vecs[2]  = '{3'b101, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 3'b001};
        vecs[3]  = '{3'b100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[4]  = '{3'b100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 3'b100, 3'b000};
        vecs[5]  = '{3'b100, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100, 3'b100};
        vecs[6]  = '{3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[7]  = '{3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[8]  = '{3'b110, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010, 3'b010};
        vecs[9]  = '{3'b111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[10] = '{3'b111, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 3'b000, 3'b100};
        vecs[11] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100, 3'b100};
        vecs[12] = '{3'b011, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[13] = '{3'b011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 3'b001};
        vecs[14] = '{3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};
        vecs[15] = '{3'b010, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010, 3'b010};
        vecs[16] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000};

        do_reset();
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req_out_valid", 64'(req_o.valid), 64'd0);
        chk("reset_okays", 64'(okay_vec()), 64'd0);

`ifdef CBUS_ARB_FIXED_PRIORITY_EN
        req[0].valid = 1'b1;
        req[1].valid = 1'b1;
        win1 = 0;
        seq_err = 0;
        for (int b = 0; b < 6; b++) begin
            tick();
            if (!busy || grant_idx != 2'd0) seq_err++;
            if (busy && grant_idx == 2'd1) win1++;
            resp_i.okay = 1'b1;
            tick();
            resp_i.last = 1'b1;
            tick();
            resp_i = '0;
        end
        chk("fixed_grant_seq", 64'(seq_err), 64'd0);
        chk("fixed_master1_wins", 64'(win1), 64'd0);
        req[0].valid = 1'b0;
        tick();
        chk("fixed_master1_after_drop", 64'({busy, grant_idx}), 64'({1'b1, 2'd1}));
        resp_i.okay = 1'b1;
        resp_i.last = 1'b1;
        tick();
        clear_inputs();
`else
        // Cycle-by-cycle vectors: contention, bubbles, rr_ptr wrap, last-without-okay.
        rd_err = 0;
        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < 3; k++) req[k].valid = vecs[i].vld[k];
            resp_i.okay  = vecs[i].okay;
            resp_i.last  = vecs[i].last;
            resp_i.rdata = 32'hA000 + 32'(i);
            #1;
            act = {22'd0, busy, (busy ? grant_idx : 2'd0), req_o.valid, okay_vec(),
                   resp_o[2].last, resp_o[1].last, resp_o[0].last,
                   (busy ? req_o.addr : 32'd0)};
            exp = {22'd0, vecs[i].busy, vecs[i].gidx, vecs[i].rov, vecs[i].okays, vecs[i].lasts,
                   (vecs[i].busy ? 32'h100 * (32'(vecs[i].gidx) + 32'd1) : 32'd0)};
            chk($sformatf("vec%0d", i), act, exp);
            for (int k = 0; k < 3; k++) if (resp_o[k].rdata !== resp_i.rdata) rd_err++;
            tick();
        end
        chk("rdata_broadcast", 64'(rd_err), 64'd0);

        // Single master, 16-word read.
        do_reset();
        req[1].valid = 1'b1;
        req[1].order = ORDER_16;
        #1;
        chk("single_first_cycle_valid", 64'(req_o.valid), 64'd0);
        tick();
        chk("single_valid_after_1", 64'({req_o.valid, grant_idx}), 64'({1'b1, 2'd1}));
        n_ok = 0;
        early_last = 0;
        other_ok = 0;
        for (int w = 0; w < 16; w++) begin
            resp_i.okay = 1'b1;
            resp_i.last = (w == 15);
            #1;
            if (resp_o[1].okay) n_ok++;
            if (resp_o[1].last != (w == 15)) early_last++;
            if (resp_o[0].okay || resp_o[2].okay) other_ok++;
            tick();
        end
        resp_i = '0;
        req[1].valid = 1'b0;
        #1;
        chk("single_okay_count", 64'(n_ok), 64'd16);
        chk("single_last_position", 64'(early_last), 64'd0);
        chk("single_other_okay", 64'(other_ok), 64'd0);
        chk("single_idle_after", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) req[k].valid = 1'b1;
        tick();
        chk("single_rr_ptr_next_is_2", 64'({busy, grant_idx}), 64'({1'b1, 2'd2}));
        resp_i.okay = 1'b1;
        resp_i.last = 1'b1;
        tick();
        clear_inputs();

        // Fairness: 12 back-to-back 4-word bursts from all masters.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req[k].valid = 1'b1;
            req[k].order = ORDER_4;
            cnt[k] = 0;
        end
        seq_err = 0;
        bubble_err = 0;
        for (int b = 0; b < 12; b++) begin
            resp_i = '0;
            #1;
            if (busy) bubble_err++;
            tick();
            if (!busy || grant_idx != 2'(b % 3)) seq_err++;
            if (busy) cnt[grant_idx]++;
            for (int w = 0; w < 4; w++) begin
                resp_i.okay = 1'b1;
                resp_i.last = (w == 3);
                tick();
            end
        end
        chk("rr_grant_sequence", 64'(seq_err), 64'd0);
        chk("rr_single_bubble", 64'(bubble_err), 64'd0);
        for (int k = 0; k < 3; k++) chk($sformatf("rr_grants_m%0d", k), 64'(cnt[k]), 64'd4);
        clear_inputs();

        // Write passthrough, 8 words from master 1.
        do_reset();
        req[1].valid    = 1'b1;
        req[1].is_write = 1'b1;
        req[1].order    = ORDER_8;
        req[1].addr     = 32'h2000;
        tick();
        wd_err = 0;
        addr_err = 0;
        gidx_err = 0;
        for (int w = 0; w < 8; w++) begin
            req[1].wdata = 32'h1000 + 32'(w);
            resp_i.okay  = 1'b1;
            resp_i.last  = (w == 7);
            #1;
            if (req_o.wdata !== 32'h1000 + 32'(w)) wd_err++;
            if (req_o.addr !== 32'h2000 || req_o.is_write !== 1'b1 || req_o.order !== ORDER_8) addr_err++;
            if (!busy || grant_idx != 2'd1 || !req_o.valid) gidx_err++;
            tick();
        end
        chk("write_wdata", 64'(wd_err), 64'd0);
        chk("write_addr_ctl", 64'(addr_err), 64'd0);
        chk("write_grant_idx", 64'(gidx_err), 64'd0);
        clear_inputs();

        // Reset mid-burst; rr_ptr is 2 going in, so a grant to 0 afterwards shows it cleared.
        req[1].valid = 1'b1;
        req[1].order = ORDER_16;
        tick();
        for (int w = 0; w < 5; w++) begin
            resp_i.okay = 1'b1;
            resp_i.last = 1'b0;
            if (w == 4) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) req[k].valid = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_req_valid", 64'(req_o.valid), 64'd0);
        chk("rst_mid_okays", 64'(okay_vec()), 64'd0);
        resp_i = '0;
        tick();
        chk("rst_mid_rr_ptr_zero", 64'({busy, grant_idx}), 64'({1'b1, 2'd0}));
        resp_i.okay = 1'b1;
        resp_i.last = 1'b1;
        tick();
        clear_inputs();
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one cache-bus (CBus) burst channel between NUM_REQ cache-side masters, e.g. 0 = ICache, 1 = DCache, 2 = uncached unit.
- Sits between the caches' cbus_req/cbus_resp ports and the single CBus-to-AXI bridge.
- Grants one master at a time and holds the grant for the whole burst, until resp.last.
- Default policy is round-robin; the optional feature switches it to fixed priority.

Parameters:
- NUM_REQ, 3, number of requesting masters (2..8).
- IDX_BITS, $clog2(NUM_REQ) (localparam), width of the grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_in  in  NUM_REQ x $bits(cbus_req_t)  per-master CBus request (valid, is_write, addr, order, wdata).
- resp_out  out  NUM_REQ x $bits(cbus_resp_t)  per-master CBus response (okay, last, rdata).
- req_out  out  $bits(cbus_req_t)  request to the downstream bridge.
- resp_in  in  $bits(cbus_resp_t)  response from the downstream bridge.
- busy  out  1  a burst is granted and in flight.
- grant_idx  out  IDX_BITS  index of the current owner; valid only while busy.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- FSM states: IDLE, GRANT.
- Registers: state, owner (IDX_BITS), rr_ptr (IDX_BITS), all reset to IDLE / 0 / 0.
- IDLE:
  - pending = OR of req_in[i].valid.
  - If pending, choose a winner: the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register owner = winner and go to GRANT next cycle.
  - req_out.valid = 0 in IDLE, so arbitration costs 1 cycle of latency.
- GRANT:
  - req_out = req_in[owner], fields passed through combinationally.
  - resp_out[owner] = resp_in.
  - Every other resp_out[j]: okay = 0, last = 0, rdata = resp_in.rdata (don't-care).
- GRANT exit: on resp_in.okay && resp_in.last:
  - Go to IDLE.
  - Set rr_ptr = owner + 1, wrapping to 0 at NUM_REQ. This is not a power-of-2 wrap; use an explicit compare.
- Simultaneous last and a new request: no same-cycle regrant. The next owner is chosen in the following IDLE cycle, so there is exactly 1 bubble between bursts.
- Ownership: the owner keeps the grant even if it drops valid mid-burst (illegal; flagged by an assertion in simulation). Non-owners may assert valid at any time; they simply wait.
- Requesters must hold addr, order and is_write stable while valid; the arbiter does not latch them.
- Outputs:
  - busy = (state == GRANT).
  - grant_idx = owner.
  - All resp_out okay/last = 0 whenever state == IDLE.
- Reset mid-burst: return to IDLE immediately and drop req_out.valid. The downstream bridge shares the same reset.
- Starvation bound: under round-robin, any valid master is granted within NUM_REQ−1 bursts.

Optional Feature:
- Macro CBUS_ARB_FIXED_PRIORITY_EN.
- Defined: winner = lowest valid index; rr_ptr is unused and held at 0. Starvation is possible by design, for ICache-first setups.
- Undefined: round-robin as specified above.

Decomposition:
- cbus_req_t, cbus_resp_t and cbus_order_t already live in the shared cache bus header; reuse them unchanged.
- Add to the shared package: arb_state_t enum {IDLE, GRANT}.
- One sub-module: cbus_rr_picker, purely combinational.
  - Inputs: valid vector, rr_ptr.
  - Outputs: winner index and any_valid.
  - Both policies are implemented inside it via the macro.

Test Plan:
- Single master: master 1 asserts read with order 4 (16 words). req_out.valid rises 1 cycle later. Master 1 receives all 16 okays, last on the 16th. Then state is IDLE and rr_ptr = 2.
- Contention: masters 0 and 2 assert valid together with rr_ptr = 0. Grant order is 0, then 2. Exactly 1 idle cycle separates the bursts, and master 2 sees okay = 0 throughout burst 0.
- Round-robin fairness: all 3 masters issue back-to-back 4-word bursts for 12 bursts. Grant sequence is 0,1,2,0,1,2,… and each master gets 4 grants.
- Write passthrough: master 1 writes an 8-word burst with wdata 0x1000+i. Downstream sees identical wdata/addr each cycle, and grant_idx = 1 throughout.
- Reset mid-burst: reset asserted at word 5 of a 16-word burst. The next cycle shows busy = 0, req_out.valid = 0, rr_ptr = 0, and all resp_out okay = 0.
- With CBUS_ARB_FIXED_PRIORITY_EN: masters 0 and 1 request continuously. Master 0 wins every arbitration and master 1 is never granted while master 0 stays valid.
